// File: rtl/iddmm_driver.sv
// iddmm_driver: loads operand words into the IDDMM multiplier RAMs, runs one
// task, buffers the N result words and replays them on a valid/ready stream.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ld_valid/ld_ready/ld_sel/ld_data  operand load stream (sel 0=x 1=y 2=m 3=m1)
//   start, busy, done            task control and status
//   wr_ena/wr_addr/wr_x/wr_y/wr_m/wr_m1  multiplier RAM write port and m1
//   task_req/task_grant/task_end/task_res  multiplier task handshake
//   res_valid/res_ready/res_data/res_last  result stream, LSW first
module iddmm_driver #(
    parameter int K      = 256,
    parameter int N      = 16,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [1:0]        ld_sel,
    input  logic [K-1:0]      ld_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [2:0]        wr_ena,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [K-1:0]      wr_x,
    output logic [K-1:0]      wr_y,
    output logic [K-1:0]      wr_m,
    output logic [K-1:0]      wr_m1,
    output logic              task_req,
    input  logic              task_grant,
    input  logic              task_end,
    input  logic [K-1:0]      task_res,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [K-1:0]      res_data,
    output logic              res_last
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] cnt [3];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W-1:0] out_idx;
    logic [ADDR_W-1:0] cap_cnt;
    logic [ADDR_W:0]   level;
    logic [K-1:0]      mem [N];
    logic [K-1:0]      wr_word;
    logic              ld_fire;
    logic              push;
    logic              pop;
    logic              empty;
    logic              last_cap;
    logic              drained;

    function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] v);
        return (v == LAST) ? '0 : v + 1'b1;
    endfunction

    // start wins over a word offered in the same cycle
    assign ld_ready = (state == S_IDLE) && !start;
    assign ld_fire  = ld_valid && ld_ready;

    assign empty    = (level == '0);
    assign push     = (state == S_RUN) && task_end;
    assign pop      = !empty && res_ready;
    assign last_cap = push && (cap_cnt == LAST);
    // leave DRAIN on the cycle the final word pops, so done follows it directly
    assign drained  = (state == S_DRAIN) &&
                      (empty || (level == (ADDR_W+1)'(1) && pop));

    assign busy      = (state != S_IDLE);
    assign task_req  = (state == S_REQ);
    assign res_valid = !empty;
    assign res_data  = empty ? '0 : mem[rptr];
    assign res_last  = !empty && (out_idx == LAST);

    assign wr_x = wr_word;
    assign wr_y = wr_word;
    assign wr_m = wr_word;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= task_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt[0]  <= '0;
            cnt[1]  <= '0;
            cnt[2]  <= '0;
            wr_ena  <= '0;
            wr_addr <= '0;
            wr_word <= '0;
            wr_m1   <= '0;
            wptr    <= '0;
            rptr    <= '0;
            out_idx <= '0;
            cap_cnt <= '0;
            level   <= '0;
            done    <= 1'b0;
        end else begin
            done   <= drained;
            wr_ena <= '0;

            if (ld_fire) begin
                if (ld_sel == 2'd3) begin
                    wr_m1 <= ld_data;
                end else begin
                    wr_ena          <= 3'b001 << ld_sel;
                    wr_addr         <= cnt[ld_sel];
                    wr_word         <= ld_data;
                    cnt[ld_sel]     <= inc(cnt[ld_sel]);
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_REQ;
                        cnt[0]  <= '0;
                        cnt[1]  <= '0;
                        cnt[2]  <= '0;
                        cap_cnt <= '0;
                    end
                end
                S_REQ: begin
                    if (task_grant) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (last_cap) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        state <= S_IDLE;
                    end
                end
            endcase

            if (push) begin
                wptr    <= inc(wptr);
                cap_cnt <= inc(cap_cnt);
            end
            if (pop) begin
                rptr    <= inc(rptr);
                out_idx <= inc(out_idx);
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (!push && pop) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iddmm_driver.sv
// tb_iddmm_driver: table-driven load checks, hand-written task sequences and
// randomized tasks compared against a queue-based reference model.
module tb_iddmm_driver;

    localparam int K  = 8;
    localparam int N  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [1:0]    ld_sel = '0;
    logic [K-1:0]  ld_data = '0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [2:0]    wr_ena;
    logic [AW-1:0] wr_addr;
    logic [K-1:0]  wr_x;
    logic [K-1:0]  wr_y;
    logic [K-1:0]  wr_m;
    logic [K-1:0]  wr_m1;
    logic          task_req;
    logic          task_grant = 1'b0;
    logic          task_end = 1'b0;
    logic [K-1:0]  task_res = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [K-1:0]  res_data;
    logic          res_last;

    iddmm_driver #(.K(K), .N(N)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_sel(ld_sel), .ld_data(ld_data),
        .start(start), .busy(busy), .done(done),
        .wr_ena(wr_ena), .wr_addr(wr_addr),
        .wr_x(wr_x), .wr_y(wr_y), .wr_m(wr_m), .wr_m1(wr_m1),
        .task_req(task_req), .task_grant(task_grant),
        .task_end(task_end), .task_res(task_res),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_last(res_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: task phase flags, word counts, result queue
    bit           in_task = 0;
    bit           granted = 0;
    int           captured = 0;
    int           delivered = 0;
    int           cnt [3] = '{0, 0, 0};
    logic [K-1:0] q [$];
    logic [2:0]   e_ena = '0;
    logic [AW-1:0] e_addr = '0;
    logic [K-1:0] e_wdata = '0;
    logic [K-1:0] e_m1 = '0;
    bit           e_done = 0;

    task automatic cycle();
        #1;
        chk("ld_ready", ld_ready, 32'(!in_task && !start));
        @(posedge clk);
        if (rst) begin
            in_task = 0; granted = 0; captured = 0; delivered = 0;
            cnt = '{0, 0, 0}; q.delete();
            e_ena = '0; e_addr = '0; e_wdata = '0; e_m1 = '0; e_done = 0;
        end else begin
            e_done = 0;
            e_ena  = '0;
            if (q.size() > 0 && res_ready) begin
                void'(q.pop_front());
                delivered++;
            end
            if (!in_task) begin
                if (start) begin
                    in_task = 1; granted = 0; captured = 0; delivered = 0;
                    cnt = '{0, 0, 0};
                end else if (ld_valid) begin
                    if (ld_sel == 2'd3) begin
                        e_m1 = ld_data;
                    end else begin
                        e_ena   = 3'(1 << ld_sel);
                        e_addr  = AW'(cnt[ld_sel]);
                        e_wdata = ld_data;
                        cnt[ld_sel] = (cnt[ld_sel] + 1) % N;
                    end
                end
            end else if (!granted) begin
                if (task_grant) granted = 1;
            end else begin
                if (captured < N && task_end) begin
                    q.push_back(task_res);
                    captured++;
                end
                if (captured == N && delivered == N) begin
                    in_task = 0;
                    e_done  = 1;
                end
            end
        end
        #1;
        chk("busy", busy, 32'(in_task));
        chk("task_req", task_req, 32'(in_task && !granted));
        chk("done", done, 32'(e_done));
        chk("wr_ena", wr_ena, 32'(e_ena));
        chk("wr_addr", wr_addr, 32'(e_addr));
        chk("wr_x", wr_x, 32'(e_wdata));
        chk("wr_y", wr_y, 32'(e_wdata));
        chk("wr_m", wr_m, 32'(e_wdata));
        chk("wr_m1", wr_m1, 32'(e_m1));
        chk("res_valid", res_valid, 32'(q.size() > 0));
        chk("res_data", res_data, (q.size() > 0) ? 32'(q[0]) : 32'd0);
        chk("res_last", res_last,
            32'(q.size() > 0 && (delivered % N) == N - 1));
    endtask

    task automatic clear_inputs();
        ld_valid = 0; start = 0; task_grant = 0; task_end = 0;
    endtask

    task automatic do_task();
        int n;
        start = 1;
        cycle();
        start = 0;
        n = 0;
        while (in_task && n < 300) begin
            ld_valid   = 1'($urandom_range(0, 1));
            ld_sel     = 2'($urandom_range(0, 3));
            ld_data    = K'($urandom);
            start      = 1'($urandom_range(0, 1));
            task_grant = ($urandom_range(0, 3) == 0);
            task_end   = 1'($urandom_range(0, 1));
            task_res   = K'($urandom);
            res_ready  = ($urandom_range(0, 3) != 0);
            cycle();
            n++;
        end
        clear_inputs();
        checks++;
        if (in_task) begin
            failures++;
            $display("FAIL task_timeout: got busy after %0d cycles required idle", n);
        end
    endtask

    typedef struct {
        logic [1:0]    sel;
        logic [K-1:0]  data;
        logic [2:0]    ena;
        logic [AW-1:0] addr;
    } ld_vec_t;

    ld_vec_t tbl [14];

    initial begin
        int reqn;
        int dones;
        logic [K-1:0] got [$];
        logic         gotl [$];
        int k;

        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 4; i++)
                tbl[s*4+i] = '{2'(s), K'(8'h10 + i), 3'(1 << s), AW'(i)};
        tbl[12] = '{2'd3, 8'hAB, 3'b000, '0};
        tbl[13] = '{2'd0, 8'h14, 3'b001, '0};

        repeat (2) @(posedge clk);
        cycle();
        rst = 0;
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_res_data", res_data, 0);

        foreach (tbl[i]) begin
            ld_valid = 1;
            ld_sel   = tbl[i].sel;
            ld_data  = tbl[i].data;
            cycle();
            chk("tbl_ena", wr_ena, 32'(tbl[i].ena));
            if (tbl[i].sel != 2'd3) begin
                chk("tbl_addr", wr_addr, 32'(tbl[i].addr));
                chk("tbl_data", wr_x, 32'(tbl[i].data));
            end else begin
                chk("tbl_m1", wr_m1, 32'(tbl[i].data));
            end
        end
        ld_valid = 0;
        cycle();
        chk("tbl_idle_ena", wr_ena, 0);

        start = 1; ld_valid = 1; ld_sel = 0; ld_data = 8'h55;
        cycle();
        chk("start_no_wr", wr_ena, 0);
        chk("start_busy", busy, 1);
        reqn = task_req ? 1 : 0;
        start = 0; ld_valid = 0; task_end = 1; task_res = 8'hEE;
        for (int i = 0; i < 6; i++) begin
            task_grant = (i == 5);
            cycle();
            if (task_req) reqn++;
        end
        clear_inputs();
        chk("req_cycles", 32'(reqn), 6);
        chk("early_end_ignored", res_valid, 0);

        res_ready = 1;
        k = 0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            task_end = (i == 0 || i == 2 || i == 5 || i == 6);
            task_res = K'(8'hA0 + k);
            if (task_end) k++;
            cycle();
            if (done) dones++;
            if (res_valid) begin
                got.push_back(res_data);
                gotl.push_back(res_last);
            end
        end
        task_end = 0;
        chk("gap_count", 32'(got.size()), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk("gap_data", 32'(got[i]), 32'(8'hA0 + i));
            chk("gap_last", 32'(gotl[i]), 32'(i == 3));
        end
        chk("gap_done_once", 32'(dones), 1);
        chk("gap_idle", busy, 0);

        start = 1; cycle(); start = 0;
        task_grant = 1; cycle(); task_grant = 0;
        res_ready = 0;
        for (int i = 0; i < 4; i++) begin
            task_end = 1;
            task_res = K'(8'hB0 + i);
            cycle();
        end
        task_end = 0;
        cycle(); cycle();
        chk("bp_valid", res_valid, 1);
        res_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_data", res_data, 32'(8'hB0 + i));
            cycle();
        end
        chk("bp_done", done, 1);
        chk("bp_busy", busy, 0);

        start = 1; cycle(); start = 0;
        task_grant = 1; cycle(); task_grant = 0;
        res_ready = 0;
        task_end = 1; task_res = 8'hC0; cycle();
        task_res = 8'hC1; cycle();
        task_end = 0;
        rst = 1;
        cycle();
        rst = 0;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_req", task_req, 0);
        chk("mid_rst_m1", wr_m1, 0);
        do_task();

        for (int t = 0; t < 8; t++) begin
            int nl;
            nl = $urandom_range(2, 8);
            for (int j = 0; j < nl; j++) begin
                ld_valid  = 1'($urandom_range(0, 1));
                ld_sel    = 2'($urandom_range(0, 3));
                ld_data   = K'($urandom);
                res_ready = 1'($urandom_range(0, 1));
                cycle();
            end
            ld_valid = 0;
            do_task();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/iddmm_driver.md
# iddmm_driver

Initiator-side sequencer for the IDDMM Montgomery multiplier (`iddmm_top`). It accepts operand words from upstream over a valid/ready load stream and writes them word-by-word into the multiplier's x/y/m RAMs, holding m1 in a register. On `start` it raises `task_req` and waits for `task_grant`. It then captures the N result words the multiplier presents on `task_res`, buffers them, and replays them downstream on a backpressurable result stream. It sits between the Paillier exponentiation controller and `iddmm_top`.

## Interface
- K, 256, bits per word
- N, 16, words per operand
- ADDR_W, $clog2(N), word address width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ld_valid  in  1  load word valid
- ld_ready  out  1  load word accepted when high with ld_valid
- ld_sel  in  2  0=x, 1=y, 2=m, 3=m1
- ld_data  in  K  load word
- start  in  1  single-cycle task start
- busy  out  1  high whenever FSM is not IDLE
- done  out  1  one-cycle pulse when task fully drained
- wr_ena  out  3  to multiplier: bit0 x, bit1 y, bit2 m write enable
- wr_addr  out  ADDR_W  to multiplier: word address
- wr_x, wr_y, wr_m  out  K  to multiplier: write data (all carry the same registered word)
- wr_m1  out  K  to multiplier: m1 register
- task_req  out  1  to multiplier: request
- task_grant  in  1  from multiplier: request accepted
- task_end  in  1  from multiplier: task_res holds a valid result word this cycle
- task_res  in  K  from multiplier: result word
- res_valid  out  1  result word valid
- res_ready  in  1  downstream accepts
- res_data  out  K  result word, LSW first
- res_last  out  1  high with word N-1

## Operation
- FSM states: IDLE, REQ, RUN, DRAIN.
- IDLE:
  - ld_ready = !start (combinational); start has priority, so a word offered in the same cycle as start is not accepted.
  - On a load handshake with sel 0–2: registered outputs next cycle are wr_ena one-hot for sel, wr_addr = cnt[sel], wr_x/y/m = ld_data. Then cnt[sel] increments, wrapping N-1→0. A word N+1 overwrites address 0.
  - On a load handshake with sel=3: wr_m1 = ld_data next cycle; wr_ena stays 0.
  - start → REQ. All three word counters clear to 0.
- REQ:
  - task_req = 1 until the cycle task_grant is sampled high, inclusive.
  - Next state RUN; task_req = 0 from that cycle on.
- RUN:
  - Each cycle with task_end = 1 pushes task_res into the result FIFO (depth N) and increments the result count.
  - Pulses need not be consecutive.
  - After the N-th capture → DRAIN.
- DRAIN: when the FIFO is empty → IDLE; done = 1 in the first IDLE cycle.
- Result stream:
  - FIFO head drives res_data; res_valid = !empty; pop on res_valid && res_ready.
  - Draining overlaps RUN.
  - res_last = 1 on the word with output index N-1.
  - res_data = 0 when empty.
- Ignored inputs: task_grant outside REQ, task_end outside RUN, start outside IDLE, ld_valid outside IDLE (ld_ready = 0 there).
- The FIFO cannot overflow, since exactly N words arrive per task. Simultaneous push and pop when full is legal.

## Timing
- Reset values: ld_ready = 1 (IDLE, start low), busy = 0, done = 0, wr_ena = 0, wr_addr = 0, wr_x/y/m = 0, wr_m1 = 0, task_req = 0, res_valid = 0, res_data = 0, res_last = 0.
- Reset clears FSM, counters, FIFO pointers and the m1 register.
- Reset mid-task: task_req drops the next cycle and buffered results are discarded. Multiplier RAM contents are not touched.
- Load latency: handshake at T → wr_ena at T+1, a single cycle.
- Start latency: start at T → busy and task_req at T+1. The last possible write (handshake at T-1) pulses wr_ena at T, before task_req.
- Grant: task_grant at G → task_req low at G+1.
- Result: task_end at E → res_valid at E+1 if the FIFO was empty. Throughput is one word per cycle with res_ready held high.
- done: last pop at D → FSM IDLE and done = 1 at D+1, busy = 0 at D+1.

## Test plan
- Reset then load x, y, m (N=4, K=8), words 0x10..0x13 per operand, plus m1 = 0xAB → wr_ena = 001/010/100, wr_addr 0..3 each; wr_m1 = 0xAB; every write exactly 1 cycle after its handshake.
- start, task_grant held low 5 cycles then high 1 cycle → task_req high exactly 6 cycles then low; busy high from start+1.
- 4 task_end pulses with gaps, data 0xA0..0xA3, res_ready = 1 → res_data A0..A3 in order, res_last only on A3, done pulses once, busy falls the same cycle.
- res_ready = 0 during all 4 captures, then 1 → 4 words buffered, none lost, drained back-to-back, done after the last pop.
- start and ld_valid in the same cycle → ld_ready = 0, no wr_ena; task_end before grant ignored; a 5th load to x wraps to wr_addr 0.
- rst asserted in RUN after 2 captures → all outputs at reset values next cycle, FIFO empty; a new full task then completes normally.
